// File: rtl/irobot_rx_pkg.sv
// Shared types and constants for the iRobot sensor-stream receive path.
// Used by rx_packet_ctrl and rx_read_strobe.
package irobot_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } rx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT      = 8'h13;
    localparam int         MAX_LEN_DEFAULT     = 32;
    localparam int         TIMEOUT_CYC_DEFAULT = 50000;

    // A length byte is legal when it is non-zero and no larger than the configured maximum.
    function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'h00) && (len <= max_len);
    endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Bundle between the RX FIFO / sensor decoder side and the packet controller.
// The controller (master) issues pops and produces frame status; the environment is the slave.
interface rx_packet_ctrl_if;

    logic       data_present;
    logic [7:0] data;
    logic       buffer_read;
    logic [7:0] pkt_byte;
    logic [5:0] pkt_idx;
    logic       pkt_valid;
    logic [5:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    modport master (
        input  data_present, data,
        output buffer_read, pkt_byte, pkt_idx, pkt_valid,
               frame_len, frame_ok, frame_err, err_code, err_cnt
    );

    modport slave (
        output data_present, data,
        input  buffer_read, pkt_byte, pkt_idx, pkt_valid,
               frame_len, frame_ok, frame_err, err_code, err_cnt
    );

endinterface

// File: rtl/rx_read_strobe.sv
// Pop-strobe generator for a first-word-fall-through buffer: at most one pop every two cycles.
// A byte is consumed on the edge that ends a buffer_read-high cycle.
module rx_read_strobe
    import irobot_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       data_present_i,
    input  logic [7:0] data_i,
    output logic       buffer_read_o,
    output logic       byte_take_o,
    output logic [7:0] byte_data_o
);

    logic rd_q;
    logic rd_d;

    // Suppressing the strobe right after a pop gives the buffer a cycle to present its next head.
    assign rd_d = data_present_i & ~rd_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign buffer_read_o = rd_q;
    assign byte_take_o   = rd_q;
    assign byte_data_o   = data_i;

endmodule

// File: rtl/rx_packet_ctrl.sv
// iRobot sensor-stream framer: header, length, payload, checksum, with frame good/bad status.
// Optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
module rx_packet_ctrl
    import irobot_rx_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         MAX_LEN     = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    rx_packet_ctrl_if.master  bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic       take;
    logic [7:0] rx_byte;
    logic       timeout_hit;

    rx_state_e  state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] frame_len_q, frame_len_d;
    logic [7:0] pkt_byte_q, pkt_byte_d;
    logic [5:0] pkt_idx_q, pkt_idx_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [7:0] csum_sum;
    logic       len_ok;
    logic       last_payload;

    rx_read_strobe u_read_strobe (
        .clk            (clk),
        .rst            (rst),
        .data_present_i (bus.data_present),
        .data_i         (bus.data),
        .buffer_read_o  (bus.buffer_read),
        .byte_take_o    (take),
        .byte_data_o    (rx_byte)
    );

    assign csum_sum     = acc_q + rx_byte;
    assign len_ok       = len_legal(rx_byte, MAX_LEN_B);
    assign last_payload = (cnt_q == frame_len_q - 6'd1);

`ifdef RX_TIMEOUT_EN
    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);

    logic [16:0] tmo_q, tmo_d;

    // A byte consumed in the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_q != HUNT) && !take && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q + 17'd1;
        if ((state_q == HUNT) || take || timeout_hit) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (take) begin
            case (state_q)
                HUNT:    if (rx_byte == HEADER) state_d = LEN;
                LEN:     state_d = len_ok ? PAYLOAD : HUNT;
                PAYLOAD: if (last_payload) state_d = CSUM;
                CSUM:    state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end else if (timeout_hit) begin
            state_d = HUNT;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        pkt_byte_d  = pkt_byte_q;
        pkt_idx_d   = pkt_idx_q;
        pkt_valid_d = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if (take) begin
            case (state_q)
                HUNT: begin
                    if (rx_byte == HEADER) acc_d = HEADER;
                end
                LEN: begin
                    if (len_ok) begin
                        frame_len_d = rx_byte[5:0];
                        cnt_d       = '0;
                        acc_d       = csum_sum;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
                PAYLOAD: begin
                    pkt_valid_d = 1'b1;
                    pkt_byte_d  = rx_byte;
                    pkt_idx_d   = cnt_q;
                    acc_d       = csum_sum;
                    cnt_d       = cnt_q + 6'd1;
                end
                CSUM: begin
                    if (csum_sum == 8'h00) begin
                        frame_ok_d = 1'b1;
                        err_code_d = ERR_NONE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end else if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        err_cnt_d = err_cnt_q;
        if (frame_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_len_q <= '0;
            pkt_byte_q  <= '0;
            pkt_idx_q   <= '0;
            pkt_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            pkt_byte_q  <= pkt_byte_d;
            pkt_idx_q   <= pkt_idx_d;
            pkt_valid_q <= pkt_valid_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.pkt_byte  = pkt_byte_q;
    assign bus.pkt_idx   = pkt_idx_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.frame_len = frame_len_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl: FWFT buffer model, frame stimulus, hand-computed expectations.
// Define RX_TIMEOUT_EN to also exercise the 100-cycle timeout build.
module tb_rx_packet_ctrl;
    import irobot_rx_pkg::*;

`ifdef RX_TIMEOUT_EN
    localparam int TB_TMO = 100;
`else
    localparam int TB_TMO = 50000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rx_packet_ctrl_if bus ();

    rx_packet_ctrl #(
        .HEADER      (8'h13),
        .MAX_LEN     (32),
        .TIMEOUT_CYC (TB_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] fifo [$];
    int         pkts [$];
    int         pop_cycs [$];
    int         cyc = 0;
    int         pop_cnt = 0;
    int         last_pop_cyc = 0;
    int         ok_ev = 0;
    int         err_ev = 0;
    int         err_cyc = 0;
    int         rd_consec = 0;
    logic       prev_rd = 1'b0;

    int checks = 0;
    int failures = 0;
    int ok0, err0, p0, pop0;

    // Buffer model: the head pops on the edge that ends a buffer_read-high cycle.
    always @(posedge clk) begin
        cyc++;
        if (bus.buffer_read === 1'b1 && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pop_cnt++;
            last_pop_cyc = cyc;
            pop_cycs.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        bus.data_present = (fifo.size() != 0);
        bus.data         = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.buffer_read && prev_rd) rd_consec++;
            prev_rd = bus.buffer_read;
            if (bus.pkt_valid) pkts.push_back((int'(bus.pkt_idx) << 8) | int'(bus.pkt_byte));
            if (bus.frame_ok) ok_ev++;
            if (bus.frame_err) begin
                err_ev++;
                err_cyc = cyc;
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_seq(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) fifo.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && fifo.size() != 0; i++) @(negedge clk);
        check("drain_budget", fifo.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic mark();
        ok0  = ok_ev;
        err0 = err_ev;
        p0   = pkts.size();
        pop0 = pop_cnt;
    endtask

    initial begin
        int gaps_bad;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_buffer_read", bus.buffer_read, 0);
        check("rst_pkt_valid", bus.pkt_valid, 0);
        check("rst_frame_len", bus.frame_len, 0);
        check("rst_frame_ok", bus.frame_ok, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good frame
        mark();
        push_seq(64'h13020708DC, 5);
        drain(100);
        check("t1_ok", ok_ev - ok0, 1);
        check("t1_err", err_ev - err0, 0);
        check("t1_npkt", pkts.size() - p0, 2);
        check("t1_pkt0", pkts[p0], 32'h007);
        check("t1_pkt1", pkts[p0+1], 32'h108);
        check("t1_frame_len", bus.frame_len, 2);
        check("t1_err_code", bus.err_code, 0);

        // Garbage before header is popped and dropped
        mark();
        push_seq(64'h55AA130105E7, 6);
        drain(100);
        check("t2_pops", pop_cnt - pop0, 6);
        check("t2_ok", ok_ev - ok0, 1);
        check("t2_npkt", pkts.size() - p0, 1);
        check("t2_pkt0", pkts[p0], 32'h005);

        // Bad checksum, then recovery
        mark();
        push_seq(64'h13010500, 4);
        drain(100);
        check("t3_err", err_ev - err0, 1);
        check("t3_ok", ok_ev - ok0, 0);
        check("t3_err_code", bus.err_code, 1);
        check("t3_err_cnt", bus.err_cnt, 1);
        mark();
        push_seq(64'h130105E7, 4);
        drain(100);
        check("t3_recover_ok", ok_ev - ok0, 1);
        check("t3_recover_code", bus.err_code, 0);

        // Length errors: zero and MAX_LEN+1
        mark();
        push_seq(64'h13001321, 4);
        drain(100);
        check("t4_err", err_ev - err0, 2);
        check("t4_err_code", bus.err_code, 2);
        check("t4_npkt", pkts.size() - p0, 0);
        check("t4_err_cnt", bus.err_cnt, 3);
        mark();
        push_seq(64'h13020708DC, 5);
        drain(100);
        check("t4_recover_ok", ok_ev - ok0, 1);
        check("t4_recover_code", bus.err_code, 0);

        // Header value inside payload is data, not a resync
        mark();
        push_seq(64'h13021313C5, 5);
        drain(100);
        check("hdr_in_payload_ok", ok_ev - ok0, 1);
        check("hdr_in_payload_npkt", pkts.size() - p0, 2);
        check("hdr_in_payload_pkt1", pkts[p0+1], 32'h113);

        // Maximum legal length: 32 bytes of 0x01, checksum 0xAD
        mark();
        push_seq(64'h1320, 2);
        for (int i = 0; i < 32; i++) fifo.push_back(8'h01);
        fifo.push_back(8'hAD);
        drain(200);
        check("maxlen_ok", ok_ev - ok0, 1);
        check("maxlen_npkt", pkts.size() - p0, 32);
        check("maxlen_last", pkts[p0+31], 32'h1F01);
        check("maxlen_frame_len", bus.frame_len, 32);

        // Handshake: 10 back-to-back bytes pop exactly every other cycle
        mark();
        for (int i = 0; i < 10; i++) fifo.push_back(8'h40 + 8'(i));
        drain(100);
        check("hs_pops", pop_cnt - pop0, 10);
        gaps_bad = 0;
        for (int i = pop0 + 1; i < pop_cnt; i++) begin
            if (pop_cycs[i] - pop_cycs[i-1] != 2) gaps_bad++;
        end
        check("hs_gaps", gaps_bad, 0);
        check("hs_no_frame", ok_ev - ok0 + err_ev - err0, 0);

        // Reset mid-frame
        mark();
        push_seq(64'h130311, 3);
        drain(100);
        push_seq(64'h2233, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.buffer_read) break;
        end
        check("rst_mid_rd_before", bus.buffer_read, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_rd_drop", bus.buffer_read, 0);
        fifo.delete();
        @(negedge clk);
        check("rst_mid_err_code", bus.err_code, 0);
        check("rst_mid_err_cnt", bus.err_cnt, 0);
        check("rst_mid_frame_len", bus.frame_len, 0);
        check("rst_mid_frame_err", bus.frame_err, 0);
        check("rst_mid_pkt_valid", bus.pkt_valid, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_no_err_pulse", err_ev - err0, 0);
        mark();
        push_seq(64'h130105E7, 4);
        drain(100);
        check("rst_mid_hunt_ok", ok_ev - ok0, 1);

        // err_cnt saturation
        mark();
        for (int i = 0; i < 260; i++) begin
            fifo.push_back(8'h13);
            fifo.push_back(8'h00);
        end
        drain(3000);
        check("sat_err_events", err_ev - err0, 260);
        check("sat_err_cnt", bus.err_cnt, 8'hFF);

        // Stalled frame
        mark();
        push_seq(64'h130211, 3);
        drain(100);
`ifdef RX_TIMEOUT_EN
        for (int i = 0; i < 300 && err_ev == err0; i++) @(negedge clk);
        check("tmo_fired", err_ev - err0, 1);
        check("tmo_delay", err_cyc - last_pop_cyc, 100);
        check("tmo_err_code", bus.err_code, 3);
`else
        repeat (300) @(negedge clk);
        check("no_tmo_err", err_ev - err0, 0);
        check("no_tmo_err_code", bus.err_code, 2);
`endif

        check("never_two_reads", rd_consec, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
